// File: rtl/yarp_pkg.sv
// yarp_pkg: shared memory-path types and the misalignment rule for the yarp core
package yarp_pkg;

    typedef enum logic [1:0] {
        BYTE      = 2'b00,
        HALF_WORD = 2'b01,
        WORD      = 2'b11
    } mem_access_size_e;

    typedef enum logic [1:0] {ARB_IDLE, ARB_REQ, ARB_RESP, ARB_DONE} arb_state_e;

    typedef enum logic {OWNER_IMEM, OWNER_DMEM} arb_owner_e;

    // size 2'b10 has no encoding, so it is rejected together with misaligned accesses
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] off);
        return (size == 2'b10) || (size == HALF_WORD && off[0]) || (size == WORD && off != 2'b00);
    endfunction

endpackage

// File: rtl/yarp_mem_lane_align.sv
// yarp_mem_lane_align: byte-lane steering for one data access
//   size, off      : access size and byte offset of the latched request
//   wdata, rdata   : right-aligned store data / raw memory read word
//   byte_en        : lane enables (0 when misaligned)
//   wdata_shifted  : store data replicated across lanes
//   rdata_aligned  : read data shifted down and zero-extended to size
//   misalign       : access cannot be issued
module yarp_mem_lane_align
    import yarp_pkg::*;
(
    input  logic [1:0]  size,
    input  logic [1:0]  off,
    input  logic [31:0] wdata,
    input  logic [31:0] rdata,
    output logic [3:0]  byte_en,
    output logic [31:0] wdata_shifted,
    output logic [31:0] rdata_aligned,
    output logic        misalign
);
    always_comb begin
        misalign      = is_misaligned(size, off);
        byte_en       = misalign ? 4'b0000 :
                        size == BYTE ? 4'b0001 << off :
                        size == HALF_WORD ? 4'b0011 << off : 4'b1111;
        wdata_shifted = size == BYTE ? {4{wdata[7:0]}} :
                        size == HALF_WORD ? {2{wdata[15:0]}} : wdata;
        rdata_aligned = (rdata >> {off, 3'b000}) &
                        (size == BYTE ? 32'h0000_00ff : size == HALF_WORD ? 32'h0000_ffff : 32'hffff_ffff);
    end
endmodule

// File: rtl/yarp_mem_arbiter.sv
// yarp_mem_arbiter: shares one 32-bit memory port between fetch and load/store
//   imem_*  : fetch request/response (word accesses, read only)
//   dmem_*  : load/store request/response with size, right-aligned data, error flag
//   mem_*   : single req/gnt/rvalid memory port, outputs held stable while mem_req_o
//   STARVE_LIMIT : data wins in a row with fetch waiting before fetch is forced through
module yarp_mem_arbiter
    import yarp_pkg::*;
#(
    parameter int STARVE_LIMIT = 4
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        imem_req_i,
    input  logic [31:0] imem_addr_i,
    output logic        imem_valid_o,
    output logic [31:0] imem_rdata_o,
    input  logic        dmem_req_i,
    input  logic        dmem_wr_i,
    input  logic [1:0]  dmem_size_i,
    input  logic [31:0] dmem_addr_i,
    input  logic [31:0] dmem_wdata_i,
    output logic        dmem_valid_o,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_err_o,
    output logic        mem_req_o,
    output logic        mem_wr_o,
    output logic [31:0] mem_addr_o,
    output logic [3:0]  mem_byte_en_o,
    output logic [31:0] mem_wdata_o,
    input  logic        mem_gnt_i,
    input  logic        mem_rvalid_i,
    input  logic [31:0] mem_rdata_i
);
    localparam logic [3:0] LIMIT = 4'(STARVE_LIMIT);

    arb_state_e  state, state_nxt;
    arb_owner_e  owner;
    logic [3:0]  starve_cnt;
    logic        wr_q;
    logic [1:0]  size_q;
    logic [31:0] addr_q, wdata_q, imem_rdata_q, dmem_rdata_q;
    logic [3:0]  lane_be;
    logic [31:0] lane_wdata, lane_rdata, addr_in;
    logic        lane_mis, any_req, pick_imem, dmem_mis;

    yarp_mem_lane_align u_align (
        .size          (size_q),
        .off           (addr_q[1:0]),
        .wdata         (wdata_q),
        .rdata         (mem_rdata_i),
        .byte_en       (lane_be),
        .wdata_shifted (lane_wdata),
        .rdata_aligned (lane_rdata),
        .misalign      (lane_mis)
    );

    always_comb begin
        any_req   = imem_req_i | dmem_req_i;
        pick_imem = imem_req_i & (~dmem_req_i | starve_cnt == LIMIT);
        dmem_mis  = is_misaligned(dmem_size_i, dmem_addr_i[1:0]);
        addr_in   = pick_imem ? imem_addr_i : dmem_addr_i;
        state_nxt = state;
        case (state)
            ARB_IDLE: state_nxt = !any_req ? ARB_IDLE : (!pick_imem && dmem_mis) ? ARB_DONE : ARB_REQ;
            ARB_REQ:  state_nxt = mem_gnt_i ? ARB_RESP : ARB_REQ;
            ARB_RESP: state_nxt = mem_rvalid_i ? ARB_DONE : ARB_RESP;
            default:  state_nxt = ARB_IDLE;
        endcase
        mem_req_o     = state == ARB_REQ;
        mem_wr_o      = mem_req_o & wr_q;
        mem_addr_o    = {addr_q[31:2], 2'b00};
        mem_byte_en_o = mem_req_o ? lane_be : 4'b0000;
        mem_wdata_o   = mem_req_o ? lane_wdata : 32'h0;
        imem_valid_o  = state == ARB_DONE && owner == OWNER_IMEM;
        dmem_valid_o  = state == ARB_DONE && owner == OWNER_DMEM;
        dmem_err_o    = dmem_valid_o & lane_mis;
        imem_rdata_o  = imem_rdata_q;
        dmem_rdata_o  = dmem_rdata_q;
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state        <= ARB_IDLE;
            owner        <= OWNER_IMEM;
            starve_cnt   <= '0;
            wr_q         <= 1'b0;
            size_q       <= '0;
            addr_q       <= '0;
            wdata_q      <= '0;
            imem_rdata_q <= '0;
            dmem_rdata_q <= '0;
        end else begin
            state <= state_nxt;
            if (state == ARB_IDLE && any_req) begin
                owner      <= pick_imem ? OWNER_IMEM : OWNER_DMEM;
                wr_q       <= !pick_imem && dmem_wr_i;
                size_q     <= pick_imem ? WORD : dmem_size_i;
                addr_q     <= {addr_in[31:2], pick_imem ? 2'b00 : addr_in[1:0]};
                wdata_q    <= pick_imem ? 32'h0 : dmem_wdata_i;
                starve_cnt <= pick_imem ? 4'd0 :
                              (imem_req_i && starve_cnt != LIMIT) ? starve_cnt + 4'd1 : starve_cnt;
                if (!pick_imem && dmem_mis)
                    dmem_rdata_q <= '0;
            end
            if (state == ARB_RESP && mem_rvalid_i) begin
                if (owner == OWNER_IMEM)
                    imem_rdata_q <= mem_rdata_i;
                else
                    dmem_rdata_q <= wr_q ? 32'h0 : lane_rdata;
            end
        end
    end
endmodule

// File: tb/tb_yarp_mem_arbiter.sv
// tb_yarp_mem_arbiter: randomized self-checking bench for yarp_mem_arbiter
module tb_yarp_mem_arbiter;
    localparam int LIMIT = 4;
    localparam logic [1:0] SZ_B = 2'b00, SZ_H = 2'b01, SZ_W = 2'b11;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        imem_req_i = 1'b0;
    logic [31:0] imem_addr_i = '0;
    logic        imem_valid_o;
    logic [31:0] imem_rdata_o;
    logic        dmem_req_i = 1'b0, dmem_wr_i = 1'b0;
    logic [1:0]  dmem_size_i = '0;
    logic [31:0] dmem_addr_i = '0, dmem_wdata_i = '0;
    logic        dmem_valid_o, dmem_err_o;
    logic [31:0] dmem_rdata_o;
    logic        mem_req_o, mem_wr_o;
    logic [31:0] mem_addr_o, mem_wdata_o;
    logic [3:0]  mem_byte_en_o;
    logic        mem_gnt_i, mem_rvalid_i;
    logic [31:0] mem_rdata_i;
    logic [136:0] all_out;

    int checks = 0, errors = 0;
    int gnt_dly = 0, rv_dly = 0;
    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [0:255];
    int grants[$];
    int reqs_seen;

    typedef struct {
        int lat; int req_cycles; bit stable; bit done; bit err;
        logic wr; logic [31:0] addr; logic [3:0] be; logic [31:0] wd; logic [31:0] rdata;
    } obs_t;

    always #5 clk = ~clk;

    assign all_out = {imem_valid_o, imem_rdata_o, dmem_valid_o, dmem_rdata_o, dmem_err_o,
                      mem_req_o, mem_wr_o, mem_addr_o, mem_byte_en_o, mem_wdata_o};

    yarp_mem_arbiter #(.STARVE_LIMIT(LIMIT)) dut (
        .clk(clk), .reset_n(reset_n),
        .imem_req_i(imem_req_i), .imem_addr_i(imem_addr_i),
        .imem_valid_o(imem_valid_o), .imem_rdata_o(imem_rdata_o),
        .dmem_req_i(dmem_req_i), .dmem_wr_i(dmem_wr_i), .dmem_size_i(dmem_size_i),
        .dmem_addr_i(dmem_addr_i), .dmem_wdata_i(dmem_wdata_i),
        .dmem_valid_o(dmem_valid_o), .dmem_rdata_o(dmem_rdata_o), .dmem_err_o(dmem_err_o),
        .mem_req_o(mem_req_o), .mem_wr_o(mem_wr_o), .mem_addr_o(mem_addr_o),
        .mem_byte_en_o(mem_byte_en_o), .mem_wdata_o(mem_wdata_o),
        .mem_gnt_i(mem_gnt_i), .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i)
    );

    // Memory on the far side of the bus: grants after gnt_dly waiting cycles,
    // answers rv_dly cycles later, and keeps a pending answer even across a DUT reset.
    initial begin
        bit pend = 0;
        int g_cnt = 0, r_cnt = 0;
        logic [31:0] resp = '0;
        mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0; mem_rdata_i = '0;
        forever begin
            @(negedge clk);
            mem_gnt_i = 1'b0; mem_rvalid_i = 1'b0;
            if (pend) begin
                if (r_cnt == 0) begin mem_rvalid_i = 1'b1; mem_rdata_i = resp; pend = 0; end
                else r_cnt--;
            end else if (mem_req_o) begin
                if (g_cnt >= gnt_dly) begin
                    mem_gnt_i = 1'b1; g_cnt = 0; pend = 1; r_cnt = rv_dly;
                    resp = mem[mem_addr_o[9:2]];
                    if (mem_wr_o)
                        for (int b = 0; b < 4; b++)
                            if (mem_byte_en_o[b]) mem[mem_addr_o[9:2]][8*b +: 8] = mem_wdata_o[8*b +: 8];
                end else g_cnt++;
            end
        end
    end

    task automatic txn(input bit is_i, input bit wr, input logic [1:0] size,
                       input logic [31:0] addr, input logic [31:0] wdata, output obs_t o);
        o = '{default: 0};
        o.stable = 1;
        @(negedge clk);
        if (is_i) begin imem_req_i = 1; imem_addr_i = addr; end
        else begin dmem_req_i = 1; dmem_wr_i = wr; dmem_size_i = size; dmem_addr_i = addr; dmem_wdata_i = wdata; end
        for (int c = 1; c <= 200 && !o.done; c++) begin
            @(posedge clk); #1;
            if (mem_req_o) begin
                if (o.req_cycles == 0) begin o.wr = mem_wr_o; o.addr = mem_addr_o; o.be = mem_byte_en_o; o.wd = mem_wdata_o; end
                else if ({mem_wr_o, mem_addr_o, mem_byte_en_o, mem_wdata_o} !== {o.wr, o.addr, o.be, o.wd}) o.stable = 0;
                o.req_cycles++;
            end
            if (is_i ? imem_valid_o : dmem_valid_o) begin
                o.done = 1; o.lat = c; o.err = dmem_err_o;
                o.rdata = is_i ? imem_rdata_o : dmem_rdata_o;
                imem_req_i = 0; dmem_req_i = 0;
            end
        end
        imem_req_i = 0; dmem_req_i = 0;
        @(posedge clk);
    endtask

    task automatic hold_both(input int n);
        grants.delete(); reqs_seen = 0;
        @(negedge clk);
        imem_req_i = 1; imem_addr_i = 32'h40;
        dmem_req_i = 1; dmem_wr_i = 0; dmem_size_i = SZ_W; dmem_addr_i = 32'h80;
        for (int c = 0; c < 400 && grants.size() < n; c++) begin
            @(posedge clk); #1;
            if (mem_req_o) reqs_seen++;
            if (imem_valid_o) grants.push_back(1);
            if (dmem_valid_o) grants.push_back(0);
        end
    endtask

    task automatic test_reset;
        reset_n = 0;
        repeat (3) @(posedge clk);
        #1; checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_hold: outputs %h, want 0", all_out); end
        @(negedge clk); reset_n = 1;
        @(posedge clk); #1; checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_release: outputs %h, want 0", all_out); end
    endtask

    task automatic test_fetch;
        obs_t o;
        gnt_dly = 0; rv_dly = 0;
        mem[8'h40] = 32'hDEADBEEF; mem[8'h41] = 32'hCAFEF00D;
        txn(1, 0, SZ_W, 32'h100, 0, o);
        checks++;
        if (!o.done || o.lat != 3) begin errors++; $display("FAIL fetch_latency: lat %0d done %0d, want 3", o.lat, o.done); end
        checks++;
        if ({o.wr, o.addr, o.be} !== {1'b0, 32'h100, 4'hF}) begin errors++; $display("FAIL fetch_bus: wr %b addr %h be %h, want 0 00000100 f", o.wr, o.addr, o.be); end
        checks++;
        if (o.req_cycles != 1) begin errors++; $display("FAIL fetch_req_cycles: %0d, want 1", o.req_cycles); end
        checks++;
        if (o.rdata !== 32'hDEADBEEF) begin errors++; $display("FAIL fetch_rdata: %h, want deadbeef", o.rdata); end
        txn(1, 0, SZ_W, 32'h107, 0, o);
        checks++;
        if (o.addr !== 32'h104 || o.rdata !== 32'hCAFEF00D) begin errors++; $display("FAIL fetch_low_bits: addr %h rdata %h, want 00000104 cafef00d", o.addr, o.rdata); end
        checks++;
        if (imem_rdata_o !== 32'hCAFEF00D) begin errors++; $display("FAIL fetch_rdata_hold: %h, want cafef00d", imem_rdata_o); end
    endtask

    task automatic test_store_load;
        obs_t o;
        mem[8'h80] = 32'h11223344;
        txn(0, 1, SZ_B, 32'h203, 32'h000000AB, o);
        checks++;
        if (!o.done || o.lat != 3) begin errors++; $display("FAIL store_latency: lat %0d, want 3", o.lat); end
        checks++;
        if ({o.wr, o.addr, o.be, o.wd} !== {1'b1, 32'h200, 4'b1000, 32'hABABABAB})
            begin errors++; $display("FAIL store_bus: wr %b addr %h be %b wd %h, want 1 00000200 1000 abababab", o.wr, o.addr, o.be, o.wd); end
        checks++;
        if ({o.rdata, o.err} !== 33'h0) begin errors++; $display("FAIL store_resp: rdata %h err %b, want 0 0", o.rdata, o.err); end
        checks++;
        if (mem[8'h80] !== 32'hAB223344) begin errors++; $display("FAIL store_effect: mem %h, want ab223344", mem[8'h80]); end
        mem[8'h80] = 32'h1234ABCD;
        txn(0, 0, SZ_H, 32'h202, 32'hFFFFFFFF, o);
        checks++;
        if ({o.wr, o.addr, o.be} !== {1'b0, 32'h200, 4'b1100}) begin errors++; $display("FAIL load_half_bus: wr %b addr %h be %b, want 0 00000200 1100", o.wr, o.addr, o.be); end
        checks++;
        if (o.rdata !== 32'h00001234) begin errors++; $display("FAIL load_half_rdata: %h, want 00001234", o.rdata); end
        txn(0, 0, SZ_B, 32'h201, 0, o);
        checks++;
        if (o.rdata !== 32'h000000AB || o.be !== 4'b0010) begin errors++; $display("FAIL load_byte: rdata %h be %b, want 000000ab 0010", o.rdata, o.be); end
    endtask

    task automatic test_misaligned;
        obs_t o;
        logic [1:0]  sz [3] = '{SZ_W, 2'b10, SZ_H};
        logic [31:0] ad [3] = '{32'h101, 32'h100, 32'h203};
        for (int i = 0; i < 3; i++) begin
            txn(0, i == 1, sz[i], ad[i], 32'h55, o);
            checks++;
            if (!o.done || o.lat != 1 || o.req_cycles != 0 || o.err !== 1'b1 || o.rdata !== 32'h0)
                begin errors++; $display("FAIL misaligned_%0d: lat %0d reqs %0d err %b rdata %h, want 1 0 1 0", i, o.lat, o.req_cycles, o.err, o.rdata); end
        end
        txn(0, 0, SZ_W, 32'h200, 0, o);
        checks++;
        if (o.err !== 1'b0 || o.rdata !== 32'h1234ABCD) begin errors++; $display("FAIL aligned_after_err: err %b rdata %h, want 0 1234abcd", o.err, o.rdata); end
    endtask

    task automatic test_starvation;
        gnt_dly = 0; rv_dly = 0;
        hold_both(10);
        imem_req_i = 0; dmem_req_i = 0;
        @(posedge clk);
        checks++;
        if (grants.size() != 10 || reqs_seen != 10) begin errors++; $display("FAIL starve_count: grants %0d reqs %0d, want 10 10", grants.size(), reqs_seen); end
        for (int k = 0; k < 10; k++) begin
            checks++;
            if ((k < grants.size() ? grants[k] : -1) != int'(k % (LIMIT + 1) == LIMIT))
                begin errors++; $display("FAIL starve_order_%0d: imem %0d, want %0d", k, k < grants.size() ? grants[k] : -1, k % (LIMIT + 1) == LIMIT); end
        end
    endtask

    task automatic test_stall;
        obs_t o;
        logic [31:0] d = $urandom;
        int extra = 0;
        gnt_dly = 5; rv_dly = 2;
        txn(0, 1, SZ_W, 32'h300, d, o);
        checks++;
        if (!o.done || o.lat != 10 || o.req_cycles != 6 || !o.stable)
            begin errors++; $display("FAIL stall_store: lat %0d reqs %0d stable %b, want 10 6 1", o.lat, o.req_cycles, o.stable); end
        checks++;
        if ({o.wr, o.addr, o.be, o.wd} !== {1'b1, 32'h300, 4'hF, d}) begin errors++; $display("FAIL stall_bus: wd %h be %h, want %h f", o.wd, o.be, d); end
        repeat (6) begin @(posedge clk); #1; if (mem_req_o || dmem_valid_o || imem_valid_o) extra++; end
        checks++;
        if (extra != 0) begin errors++; $display("FAIL stall_duplicate: %0d extra cycles, want 0", extra); end
        txn(0, 0, SZ_W, 32'h300, 0, o);
        checks++;
        if (o.lat != 10 || o.rdata !== d) begin errors++; $display("FAIL stall_load: lat %0d rdata %h, want 10 %h", o.lat, o.rdata, d); end
        gnt_dly = 0; rv_dly = 0;
    endtask

    task automatic test_reset_mid;
        obs_t o;
        bit seen = 0;
        int quiet = 0;
        gnt_dly = 0; rv_dly = 0;
        hold_both(3);
        rv_dly = 4;
        for (int c = 0; c < 50 && !(seen && !mem_req_o); c++) begin @(posedge clk); #1; if (mem_req_o) seen = 1; end
        checks++;
        if (!(seen && !mem_req_o)) begin errors++; $display("FAIL reset_mid_reach: seen %b req %b, want 1 0", seen, mem_req_o); end
        @(negedge clk); reset_n = 0; imem_req_i = 0; dmem_req_i = 0;
        @(posedge clk); #1; checks++;
        if (all_out !== '0) begin errors++; $display("FAIL reset_mid_outputs: %h, want 0", all_out); end
        @(negedge clk); reset_n = 1;
        repeat (10) begin @(posedge clk); #1; if (imem_valid_o || dmem_valid_o || mem_req_o) quiet++; end
        checks++;
        if (quiet != 0) begin errors++; $display("FAIL reset_mid_late_rvalid: %0d active cycles, want 0", quiet); end
        rv_dly = 0;
        hold_both(5);
        imem_req_i = 0; dmem_req_i = 0;
        @(posedge clk);
        checks++;
        if (grants.size() != 5 || grants[0] != 0 || grants[3] != 0 || grants[4] != 1)
            begin errors++; $display("FAIL reset_mid_starve_clear: %0d grants, last imem %0d, want 5 1", grants.size(), grants.size() > 4 ? grants[4] : -1); end
        mem[8'h10] = 32'h600DF00D;
        txn(1, 0, SZ_W, 32'h40, 0, o);
        checks++;
        if (o.lat != 3 || o.rdata !== 32'h600DF00D) begin errors++; $display("FAIL reset_mid_fetch: lat %0d rdata %h, want 3 600df00d", o.lat, o.rdata); end
    endtask

    task automatic test_random;
        obs_t o;
        for (int i = 0; i < 256; i++) begin mem[i] = $urandom; ref_mem[i] = mem[i]; end
        for (int t = 0; t < 60; t++) begin
            bit is_i = $urandom_range(0, 3) == 0;
            bit wr = $urandom_range(0, 1) == 1;
            logic [1:0]  size = 2'($urandom_range(0, 3));
            logic [31:0] addr = 32'($urandom_range(0, 1023));
            logic [31:0] wd = $urandom;
            int off = int'(addr[1:0]), idx = int'(addr[9:2]);
            int n = size == SZ_B ? 1 : size == SZ_H ? 2 : 4;
            bit bad = !is_i && (size == 2'b10 || (size == SZ_H && off % 2 == 1) || (size == SZ_W && off != 0));
            logic [31:0] mask = n == 4 ? 32'hFFFFFFFF : (32'h1 << (8 * n)) - 1;
            logic [31:0] erd, ewd;
            logic [3:0] ebe;
            int elat;
            gnt_dly = $urandom_range(0, 3); rv_dly = $urandom_range(0, 3);
            elat = bad ? 1 : 3 + gnt_dly + rv_dly;
            ebe = is_i ? 4'hF : 4'(((1 << n) - 1) << off);
            ewd = n == 1 ? wd[7:0] * 32'h01010101 : n == 2 ? wd[15:0] * 32'h00010001 : wd;
            erd = is_i ? ref_mem[idx & ~0] : (bad || wr) ? 32'h0 : (ref_mem[idx] >> (8 * off)) & mask;
            if (is_i) erd = ref_mem[idx];
            if (!is_i && !bad && wr)
                for (int b = 0; b < n; b++) ref_mem[idx][8 * (off + b) +: 8] = wd[8 * b +: 8];
            txn(is_i, wr, size, addr, wd, o);
            checks++;
            if (!o.done || o.lat != elat || o.req_cycles != (bad ? 0 : gnt_dly + 1))
                begin errors++; $display("FAIL rand_timing_%0d: lat %0d reqs %0d, want %0d %0d", t, o.lat, o.req_cycles, elat, bad ? 0 : gnt_dly + 1); end
            checks++;
            if (o.rdata !== erd || o.err !== bad) begin errors++; $display("FAIL rand_data_%0d: rdata %h err %b, want %h %b", t, o.rdata, o.err, erd, bad); end
            if (!bad) begin
                checks++;
                if (!o.stable || o.be !== ebe || o.wr !== (!is_i && wr) || o.addr !== {addr[31:2], 2'b00} || (!is_i && wr && o.wd !== ewd))
                    begin errors++; $display("FAIL rand_bus_%0d: be %b wr %b addr %h wd %h, want %b %b %h %h", t, o.be, o.wr, o.addr, o.wd, ebe, !is_i && wr, {addr[31:2], 2'b00}, ewd); end
            end
        end
        gnt_dly = 0; rv_dly = 0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1, "timeout");
    end

    initial begin
        for (int i = 0; i < 256; i++) mem[i] = '0;
        test_reset;
        test_fetch;
        test_store_load;
        test_misaligned;
        test_starvation;
        test_stall;
        test_reset_mid;
        test_random;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
